asic_iopoc_seq: RTL

// - Power-on sequencer for the padring power-on-control ring. Runs off the

---
 rtl/asic_iopoc_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/asic_iopoc_seq.sv
// -----------------------------------------------------------------------------
// asic_iopoc_seq -- power-on sequencer for the padring power-on-control ring.
//
// Runs on the always-on core clock and drives the ctrlring bus that is
// daisy-chained through every POC cell. Once both supplies are good and go is
// high, pads are walked through a supply settle wait, an isolation/driver
// overlap window and finally core reset release. Supply loss or go=0 forces
// the pads back to the safe state (iso=1).
//
// Ports:
//   clk       in   1      always-on core clock
//   nreset    in   1      asynchronous active-low reset
//   vdd_ok    in   1      core supply good (asynchronous, synchronized here)
//   vddio_ok  in   1      io supply good (asynchronous, synchronized here)
//   go        in   1      synchronous power-up request level; 0 = shut down
//   ctrlring  out  NCTRL  [0]=iso [1]=io_en [2]=por_n [3]=ready, rest 0
//   state     out  3      current FSM state (debug)
//   ready     out  1      pads fully enabled (equals ctrlring[3])
//   fault     out  1      power-up timeout flag
//
// Configuration macro: IOPOC_SEQ_TIMEOUT_EN
//   defined   : OFF waiting with go=1 and supplies bad for TIMEOUT cycles
//               enters FAULT; FAULT is left only through go=0.
//   undefined : no wait counter, fault tied low, OFF waits indefinitely.
// -----------------------------------------------------------------------------
module asic_iopoc_seq #(
  parameter int NCTRL    = 8,
  parameter int T_SETTLE = 16,
  parameter int T_ISO    = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             vdd_ok,
  input  logic             vddio_ok,
  input  logic             go,
  output logic [NCTRL-1:0] ctrlring,
  output logic [2:0]       state,
  output logic             ready,
  output logic             fault
);

  localparam int T_MAX = (T_SETTLE > T_ISO)
                       ? ((T_SETTLE > TIMEOUT) ? T_SETTLE : TIMEOUT)
                       : ((T_ISO    > TIMEOUT) ? T_ISO    : TIMEOUT);
  localparam int CW = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ISO    = 3'd2,
    ST_ON     = 3'd3,
    ST_DOWN   = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // Ring encodings, bit order {ready, por_n, io_en, iso}.
  localparam logic [3:0] CTRL_SAFE = 4'h1;
  localparam logic [3:0] CTRL_ISO  = 4'h3;
  localparam logic [3:0] CTRL_ON   = 4'hE;

  localparam logic [CW-1:0] LOAD_SETTLE = CW'(T_SETTLE - 1);
  localparam logic [CW-1:0] LOAD_ISO    = CW'(T_ISO - 1);

  function automatic logic [3:0] ctrl_of(input state_e s);
    case (s)
      ST_ISO,
      ST_DOWN: ctrl_of = CTRL_ISO;
      ST_ON:   ctrl_of = CTRL_ON;
      default: ctrl_of = CTRL_SAFE;
    endcase
  endfunction

  // Two-flop synchronizers for the asynchronous supply-good pins.
  logic r_vdd_s1, r_vdd_s2, r_vio_s1, r_vio_s2;
  logic w_ok_s;

  state_e          r_state, w_nxt_state;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic [3:0]      r_ctrl;

`ifdef IOPOC_SEQ_TIMEOUT_EN
  logic [CW-1:0]   r_wait, w_nxt_wait;
  logic            r_fault;
`endif

  assign w_ok_s = r_vdd_s2 & r_vio_s2;

  // Next-state and counter logic. Priority within each state is
  // supply loss, then go deassert, then counter expiry.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    w_nxt_state = r_state;
    w_nxt_cnt   = '0;
`ifdef IOPOC_SEQ_TIMEOUT_EN
    w_nxt_wait  = '0;
`endif
    case (r_state)
      ST_OFF: begin
        if (go && w_ok_s) begin
          w_nxt_state = ST_SETTLE;
          w_nxt_cnt   = LOAD_SETTLE;
        end
`ifdef IOPOC_SEQ_TIMEOUT_EN
        else if (go) begin
          // Waiting for supplies with a pending request.
          if (r_wait == CW'(TIMEOUT - 1)) w_nxt_state = ST_FAULT;
          else                            w_nxt_wait  = r_wait + CW'(1);
        end
`endif
      end
      ST_SETTLE: begin
        if (!w_ok_s || !go) begin
          w_nxt_state = ST_OFF;
        end else if (r_cnt == '0) begin
          w_nxt_state = ST_ISO;
          w_nxt_cnt   = LOAD_ISO;
        end else begin
          w_nxt_cnt   = r_cnt - CW'(1);
        end
      end
      ST_ISO: begin
        if (!w_ok_s) begin
          w_nxt_state = ST_OFF;
        end else if (!go) begin
          w_nxt_state = ST_DOWN;
          w_nxt_cnt   = LOAD_ISO;
        end else if (r_cnt == '0) begin
          w_nxt_state = ST_ON;
        end else begin
          w_nxt_cnt   = r_cnt - CW'(1);
        end
      end
      ST_ON: begin
        if (!w_ok_s) begin
          w_nxt_state = ST_OFF;
        end else if (!go) begin
          w_nxt_state = ST_DOWN;
          w_nxt_cnt   = LOAD_ISO;
        end
      end
      ST_DOWN: begin
        // go is deliberately ignored here: shutdown always completes.
        if (!w_ok_s || r_cnt == '0) w_nxt_state = ST_OFF;
        else                        w_nxt_cnt   = r_cnt - CW'(1);
      end
      ST_FAULT: begin
        // Only a withdrawn request clears the fault; good supplies do not.
        if (!go) w_nxt_state = ST_OFF;
      end
      default: w_nxt_state = ST_OFF;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // the ring changes on the same edge as state and never glitches.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_vdd_s1 <= 1'b0;
      r_vdd_s2 <= 1'b0;
      r_vio_s1 <= 1'b0;
      r_vio_s2 <= 1'b0;
      r_state  <= ST_OFF;
      r_cnt    <= '0;
      r_ctrl   <= CTRL_SAFE;
`ifdef IOPOC_SEQ_TIMEOUT_EN
      r_wait   <= '0;
      r_fault  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, so the synchronizer stages really are separate stages.
      r_vdd_s1 <= vdd_ok;
      r_vdd_s2 <= r_vdd_s1;
      r_vio_s1 <= vddio_ok;
      r_vio_s2 <= r_vio_s1;
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_ctrl   <= ctrl_of(w_nxt_state);
`ifdef IOPOC_SEQ_TIMEOUT_EN
      r_wait   <= w_nxt_wait;
      r_fault  <= (w_nxt_state == ST_FAULT);
`endif
    end
  end

  assign ctrlring = NCTRL'(r_ctrl);
  assign state    = r_state;
  assign ready    = r_ctrl[3];
`ifdef IOPOC_SEQ_TIMEOUT_EN
  assign fault    = r_fault;
`else
  assign fault    = 1'b0;
`endif

endmodule
